ili9341_pixel_writer: RTL and testbench

Downstream stage of the ILI9341 power-up initialiser. It stays idle until the initialiser's ready output is high. It then accepts rectangular window requests, sends CASET (0x2A), PASET (0x2B) and RAMWR (0x2C) with their arguments over the 4-wire SPI bus, and streams RGB565 pixels from a valid/ready source until the window is filled. The SPI bus is shared with the initialiser; the top level selects which block drives the bus, based on init_ready.

---
 rtl/ili9341_pixel_writer_pkg.sv | 40 ++++
 rtl/ili9341_pixel_writer_if.sv | 26 ++
 rtl/ili9341_spi_byte_tx.sv | 69 ++++++
 rtl/ili9341_pixel_writer.sv | 149 ++++++++++++++
 tb/tb_ili9341_pixel_writer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ili9341_pixel_writer_pkg.sv
// Shared definitions for the ILI9341 pixel writer: command opcodes, FSM
// encoding, default panel limits and the coordinate byte selector.
package ili9341_pixel_writer_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int MAX_X_DEFAULT = 239;
  localparam int MAX_Y_DEFAULT = 319;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CASET_C,
    ST_CASET_D,
    ST_PASET_C,
    ST_PASET_D,
    ST_RAMWR_C,
    ST_PIX_FETCH,
    ST_PIX_HI,
    ST_PIX_LO,
    ST_FINISH
  } state_e;

  // Argument bytes of CASET/PASET: start hi, start lo, end hi, end lo,
  // with the 9-bit coordinates zero-extended to 16 bits.
  function automatic logic [7:0] coord_byte(input logic [8:0] first,
                                            input logic [8:0] last,
                                            input logic [1:0] idx);
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = {7'b0, first[8]};
      2'd1:    b = first[7:0];
      2'd2:    b = {7'b0, last[8]};
      default: b = last[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ili9341_pixel_writer_if.sv
// Window/pixel handshakes and the 4-wire SPI panel bus of the pixel writer.
interface ili9341_pixel_writer_if;
  logic        win_valid;
  logic        win_ready;
  logic [8:0]  win_x0;
  logic [8:0]  win_x1;
  logic [8:0]  win_y0;
  logic [8:0]  win_y1;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data;
  logic        tft_cs;
  logic        tft_dc;
  logic        tft_sclk;
  logic        tft_din;

  modport master (
    output win_valid, win_x0, win_x1, win_y0, win_y1, pix_valid, pix_data,
    input  win_ready, pix_ready, tft_cs, tft_dc, tft_sclk, tft_din
  );

  modport slave (
    input  win_valid, win_x0, win_x1, win_y0, win_y1, pix_valid, pix_data,
    output win_ready, pix_ready, tft_cs, tft_dc, tft_sclk, tft_din
  );
endinterface

// File: rtl/ili9341_spi_byte_tx.sv
// SPI mode-0 byte shifter: MSB first, each bit CLK_DIV cycles low then
// CLK_DIV cycles high. byte_done marks the cycle before the final falling edge.
module ili9341_spi_byte_tx #(
  parameter int CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       dc,
  output logic       sclk,
  output logic       din,
  output logic       dc_out,
  output logic       busy,
  output logic       byte_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [6:0]    shreg;
  logic          phase_end;

  assign phase_end = (cnt == CW'(CLK_DIV - 1));
  // Raised while the last high phase ends so the sequencer can present the
  // next byte right as SCLK falls, keeping the inter-byte low gap short.
  assign byte_done = busy & sclk & phase_end & (bit_idx == 3'd7);

  // NOTE: registers update with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      sclk    <= 1'b0;
      din     <= 1'b0;
      dc_out  <= 1'b0;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 7'd0;
    end else if (!busy) begin
      if (start) begin
        busy    <= 1'b1;
        sclk    <= 1'b0;
        din     <= tx_byte[7];
        shreg   <= tx_byte[6:0];
        dc_out  <= dc;
        cnt     <= '0;
        bit_idx <= 3'd0;
      end
    end else if (phase_end) begin
      cnt <= '0;
      if (!sclk) begin
        sclk <= 1'b1;
      end else begin
        sclk <= 1'b0;
        if (bit_idx == 3'd7) begin
          busy <= 1'b0;
        end else begin
          bit_idx <= bit_idx + 3'd1;
          din     <= shreg[6];
          shreg   <= {shreg[5:0], 1'b0};
        end
      end
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ili9341_pixel_writer.sv
// ILI9341 window writer: validates a window, sends CASET/PASET/RAMWR with
// arguments, then streams the window's RGB565 pixels over SPI.
module ili9341_pixel_writer
  import ili9341_pixel_writer_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int MAX_X   = MAX_X_DEFAULT,
  parameter int MAX_Y   = MAX_Y_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_ready,
  ili9341_pixel_writer_if.slave  bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam logic [8:0] MAX_X9 = 9'(MAX_X);
  localparam logic [8:0] MAX_Y9 = 9'(MAX_Y);

  state_e      state_q, state_d;
  logic [8:0]  x0_q, x1_q, y0_q, y1_q;
  logic [16:0] pix_cnt_q;
  logic [7:0]  pix_lo_q;
  logic [1:0]  idx_q;
  logic        err_q;

  logic        win_ready_w, win_hs, win_bad, pix_hs;
  logic [16:0] win_w, win_h, win_pixels;

  logic        tx_start, tx_dc, tx_busy, tx_done;
  logic [7:0]  tx_byte;
  logic        sclk_w, din_w, dc_w, cs_w, pix_ready_w;

  assign win_ready_w = (state_q == ST_IDLE) & init_ready & ~rst;
  assign win_hs      = bus.win_valid & win_ready_w;
  assign pix_hs      = (state_q == ST_PIX_FETCH) & bus.pix_valid;

  assign win_bad = (bus.win_x1 < bus.win_x0) | (bus.win_y1 < bus.win_y0) |
                   (bus.win_x1 > MAX_X9)     | (bus.win_y1 > MAX_Y9);
  // Only loaded for legal windows, whose product always fits 17 bits.
  assign win_w      = 17'(bus.win_x1) - 17'(bus.win_x0) + 17'd1;
  assign win_h      = 17'(bus.win_y1) - 17'(bus.win_y0) + 17'd1;
  assign win_pixels = win_w * win_h;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (win_hs) state_d = win_bad ? ST_FINISH : ST_CASET_C;
      ST_CASET_C:   if (tx_done) state_d = ST_CASET_D;
      ST_CASET_D:   if (tx_done && idx_q == 2'd3) state_d = ST_PASET_C;
      ST_PASET_C:   if (tx_done) state_d = ST_PASET_D;
      ST_PASET_D:   if (tx_done && idx_q == 2'd3) state_d = ST_RAMWR_C;
      ST_RAMWR_C:   if (tx_done) state_d = ST_PIX_FETCH;
      ST_PIX_FETCH: if (bus.pix_valid) state_d = ST_PIX_HI;
      ST_PIX_HI:    if (tx_done) state_d = ST_PIX_LO;
      ST_PIX_LO:    if (tx_done) state_d = (pix_cnt_q == 17'd0) ? ST_FINISH : ST_PIX_FETCH;
      ST_FINISH:    state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // CS drops together with the first byte load so it leads the first SCLK
  // rise by one bit-low phase, and stays low until FINISH.
  always_comb begin
    // NOTE: every output is defaulted before the case, so no path infers a latch.
    tx_start    = 1'b0;
    tx_byte     = 8'h00;
    tx_dc       = 1'b1;
    pix_ready_w = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    cs_w        = (state_q == ST_IDLE) || (state_q == ST_FINISH) ||
                  (state_q == ST_CASET_C && !tx_busy);
    busy        = (state_q != ST_IDLE);
    unique case (state_q)
      ST_CASET_C: begin tx_byte = CMD_CASET; tx_dc = 1'b0; tx_start = ~tx_busy; end
      ST_CASET_D: begin tx_byte = coord_byte(x0_q, x1_q, idx_q); tx_start = ~tx_busy; end
      ST_PASET_C: begin tx_byte = CMD_PASET; tx_dc = 1'b0; tx_start = ~tx_busy; end
      ST_PASET_D: begin tx_byte = coord_byte(y0_q, y1_q, idx_q); tx_start = ~tx_busy; end
      ST_RAMWR_C: begin tx_byte = CMD_RAMWR; tx_dc = 1'b0; tx_start = ~tx_busy; end
      // The high byte launches on the handshake itself to avoid an extra idle cycle.
      ST_PIX_FETCH: begin
        pix_ready_w = 1'b1;
        tx_byte     = bus.pix_data[15:8];
        tx_start    = bus.pix_valid;
      end
      ST_PIX_LO: begin tx_byte = pix_lo_q; tx_start = ~tx_busy; end
      ST_FINISH: begin done = 1'b1; err = err_q; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q      <= 9'd0;
      x1_q      <= 9'd0;
      y0_q      <= 9'd0;
      y1_q      <= 9'd0;
      pix_cnt_q <= 17'd0;
      pix_lo_q  <= 8'd0;
      idx_q     <= 2'd0;
      err_q     <= 1'b0;
    end else begin
      if (win_hs) begin
        x0_q      <= bus.win_x0;
        x1_q      <= bus.win_x1;
        y0_q      <= bus.win_y0;
        y1_q      <= bus.win_y1;
        pix_cnt_q <= win_pixels;
        err_q     <= win_bad;
        idx_q     <= 2'd0;
      end
      if (pix_hs) begin
        pix_lo_q  <= bus.pix_data[7:0];
        pix_cnt_q <= pix_cnt_q - 17'd1;
      end
      if (tx_done && (state_q == ST_CASET_D || state_q == ST_PASET_D))
        idx_q <= idx_q + 2'd1;
    end
  end

  ili9341_spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .start     (tx_start),
    .tx_byte   (tx_byte),
    .dc        (tx_dc),
    .sclk      (sclk_w),
    .din       (din_w),
    .dc_out    (dc_w),
    .busy      (tx_busy),
    .byte_done (tx_done)
  );

  assign bus.win_ready = win_ready_w;
  assign bus.pix_ready = pix_ready_w;
  assign bus.tft_cs    = cs_w;
  assign bus.tft_dc    = dc_w;
  assign bus.tft_sclk  = sclk_w;
  assign bus.tft_din   = din_w;

endmodule

// File: tb/tb_ili9341_pixel_writer.sv
// Directed bench for ili9341_pixel_writer: decodes the SPI bus into
// {dc,byte} entries and checks them against hand-written command streams.
module tb_ili9341_pixel_writer;

  logic        clk, rst, init_ready;
  logic        win_valid, pix_valid;
  logic [8:0]  win_x0, win_x1, win_y0, win_y1;
  logic [15:0] pix_data;
  logic        win_ready, pix_ready, tft_cs, tft_dc, tft_sclk, tft_din;
  logic        busy, done, err;

  ili9341_pixel_writer_if bus_if ();

  assign bus_if.win_valid = win_valid;
  assign bus_if.win_x0    = win_x0;
  assign bus_if.win_x1    = win_x1;
  assign bus_if.win_y0    = win_y0;
  assign bus_if.win_y1    = win_y1;
  assign bus_if.pix_valid = pix_valid;
  assign bus_if.pix_data  = pix_data;
  assign win_ready = bus_if.win_ready;
  assign pix_ready = bus_if.pix_ready;
  assign tft_cs    = bus_if.tft_cs;
  assign tft_dc    = bus_if.tft_dc;
  assign tft_sclk  = bus_if.tft_sclk;
  assign tft_din   = bus_if.tft_din;

  ili9341_pixel_writer #(.CLK_DIV(1), .MAX_X(239), .MAX_Y(319)) dut (
    .clk        (clk),
    .rst        (rst),
    .init_ready (init_ready),
    .bus        (bus_if),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bus and event monitors ----------------
  logic [8:0] mon_q[$];
  logic [6:0] mon_sh = 7'd0;
  logic [3:0] mon_bits = 4'd0;
  int sclk_edges = 0, cs_high_edges = 0;
  int pix_hs = 0, done_cnt = 0, err_cnt = 0, de_cnt = 0, cs_fall = 0, wr_seen = 0;
  int low_run = 0, max_low = 0;
  logic cs_prev = 1'b1;

  always @(posedge tft_sclk or posedge tft_cs) begin
    if (tft_cs) begin
      mon_bits <= 4'd0;
      if (tft_sclk) cs_high_edges <= cs_high_edges + 1;
    end else if (mon_bits == 4'd7) begin
      mon_q.push_back({tft_dc, mon_sh, tft_din});
      mon_bits <= 4'd0;
    end else begin
      mon_sh   <= {mon_sh[5:0], tft_din};
      mon_bits <= mon_bits + 4'd1;
    end
  end

  always @(posedge tft_sclk) sclk_edges <= sclk_edges + 1;

  always @(negedge clk) begin
    if (pix_valid && pix_ready) pix_hs <= pix_hs + 1;
    if (win_ready) wr_seen <= wr_seen + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (done && err) de_cnt <= de_cnt + 1;
    if (cs_prev && !tft_cs) cs_fall <= cs_fall + 1;
    cs_prev <= tft_cs;
    // SCLK-low run inside a transaction, excluding pixel-fetch waits.
    if (!tft_cs && !tft_sclk && !pix_ready) begin
      low_run <= low_run + 1;
      if (low_run + 1 > max_low) max_low <= low_run + 1;
    end else begin
      low_run <= 0;
    end
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0, n_fail = 0;
  logic [8:0]  exp_q[$];
  logic [15:0] px [0:15];
  int d0, e0, de0, cf0, sc0, ph0, ce0, base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic snap();
    d0 = done_cnt; e0 = err_cnt; de0 = de_cnt; cf0 = cs_fall;
    sc0 = sclk_edges; ph0 = pix_hs; ce0 = cs_high_edges; base = mon_q.size();
  endtask

  task automatic send_win(input logic [8:0] x0, x1, y0, y1);
    int g = 0;
    win_x0 = x0; win_x1 = x1; win_y0 = y0; win_y1 = y1; win_valid = 1'b1;
    do begin @(negedge clk); g++; end while (!win_ready && g < 100);
    @(posedge clk); #1;
    win_valid = 1'b0;
  endtask

  task automatic run_px(input int n, input int stall_at);
    int k = 0, g = 0;
    logic hs;
    pix_valid = 1'b1; pix_data = px[0];
    while (k < n && g < 6000) begin
      @(negedge clk); hs = pix_ready; g++;
      @(posedge clk); #1;
      if (hs) begin
        k++;
        if (k == stall_at) begin
          pix_valid = 1'b0;
          repeat (49) @(posedge clk);
          @(negedge clk);
          check("stall_cs_sclk_ready_busy", {tft_cs, tft_sclk, pix_ready, busy}, 4'b0011);
          @(posedge clk); #1;
        end
        if (k < n) begin pix_valid = 1'b1; pix_data = px[k]; end
        else pix_valid = 1'b0;
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (done_cnt == d0 && g < 5000) begin @(negedge clk); g++; end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic cmp_bus(input string tag);
    check({tag, "_nbytes"}, mon_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < mon_q.size())
        check($sformatf("%s_b%0d", tag, i), 32'(mon_q[base + i]), 32'(exp_q[i]));
  endtask

  task automatic txn_checks(input string tag, input int npix);
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_err"}, err_cnt - e0, 0);
    check({tag, "_pix_hs"}, pix_hs - ph0, npix);
    check({tag, "_cs_fall"}, cs_fall - cf0, 1);
    check({tag, "_sclk_cs_high"}, cs_high_edges - ce0, 0);
    check({tag, "_idle_after"}, {busy, tft_cs, tft_sclk}, 3'b010);
  endtask

  task automatic reject_checks(input string tag);
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_err"}, err_cnt - e0, 1);
    check({tag, "_same_cycle"}, de_cnt - de0, 1);
    check({tag, "_cs_fall"}, cs_fall - cf0, 0);
    check({tag, "_sclk"}, sclk_edges - sc0, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; init_ready = 1'b0; win_valid = 1'b1;
    win_x0 = 9'd0; win_x1 = 9'd1; win_y0 = 9'd0; win_y1 = 9'd0;
    pix_valid = 1'b0; pix_data = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {tft_cs, tft_dc, tft_sclk, tft_din, win_ready, pix_ready, busy, done, err}, 9'h100);
    @(posedge clk); #1 rst = 1'b0;

    // init_ready low: request held, nothing may happen
    snap();
    repeat (1000) @(posedge clk);
    @(negedge clk);
    check("noinit_win_ready", wr_seen, 0);
    check("noinit_sclk", sclk_edges - sc0, 0);
    check("noinit_cs_fall", cs_fall - cf0, 0);
    check("noinit_busy_cs", {busy, tft_cs}, 2'b01);
    @(posedge clk); #1;
    win_valid = 1'b0; init_ready = 1'b1;
    repeat (2) @(posedge clk); #1;

    // 2x1 window, two pixels
    snap();
    exp_q = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h101,
              9'h02B, 9'h100, 9'h100, 9'h100, 9'h100,
              9'h02C, 9'h1F8, 9'h100, 9'h107, 9'h1E0};
    px[0] = 16'hF800; px[1] = 16'h07E0;
    send_win(9'd0, 9'd1, 9'd0, 9'd0);
    run_px(2, 0);
    wait_done();
    cmp_bus("w2x1");
    txn_checks("w2x1", 2);

    // 1x1 window
    snap();
    exp_q = '{9'h02A, 9'h100, 9'h10A, 9'h100, 9'h10A,
              9'h02B, 9'h100, 9'h114, 9'h100, 9'h114,
              9'h02C, 9'h112, 9'h134};
    px[0] = 16'h1234;
    send_win(9'd10, 9'd10, 9'd20, 9'd20);
    run_px(1, 0);
    wait_done();
    cmp_bus("w1x1");
    txn_checks("w1x1", 1);

    // rejected windows
    snap();
    send_win(9'd5, 9'd4, 9'd0, 9'd0);
    repeat (5) @(posedge clk); #1;
    reject_checks("rej_x1_lt_x0");
    snap();
    send_win(9'd0, 9'd0, 9'd0, 9'd320);
    repeat (5) @(posedge clk); #1;
    reject_checks("rej_y1_320");
    snap();
    send_win(9'd0, 9'd240, 9'd0, 9'd0);
    repeat (5) @(posedge clk); #1;
    reject_checks("rej_x1_240");

    // 4x4 window with a 50-cycle source stall after pixel 3; rows above 255
    snap();
    exp_q = '{9'h02A, 9'h100, 9'h164, 9'h100, 9'h167,
              9'h02B, 9'h101, 9'h12C, 9'h101, 9'h12F,
              9'h02C};
    for (int i = 0; i < 16; i++) begin
      px[i] = 16'h0F00 + 16'(i) * 16'h1001;
      exp_q.push_back({1'b1, px[i][15:8]});
      exp_q.push_back({1'b1, px[i][7:0]});
    end
    send_win(9'd100, 9'd103, 9'd300, 9'd303);
    run_px(16, 3);
    wait_done();
    cmp_bus("w4x4");
    txn_checks("w4x4", 16);

    // reset in the middle of PASET arguments
    snap();
    send_win(9'd1, 9'd3, 9'd2, 9'd4);
    begin
      int g = 0;
      while (mon_q.size() < base + 7 && g < 2000) begin @(negedge clk); g++; end
    end
    check("pre_rst_paset_cmd", (mon_q.size() > base + 5) ? 32'(mon_q[base + 5]) : 32'hDEAD, 9'h02B);
    repeat (5) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_cs_busy_sclk", {tft_cs, busy, tft_sclk}, 3'b100);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk); #1;

    snap();
    exp_q = '{9'h02A, 9'h100, 9'h102, 9'h100, 9'h102,
              9'h02B, 9'h100, 9'h103, 9'h100, 9'h103,
              9'h02C, 9'h1BE, 9'h1EF};
    px[0] = 16'hBEEF;
    send_win(9'd2, 9'd2, 9'd3, 9'd3);
    run_px(1, 0);
    wait_done();
    cmp_bus("after_rst");
    txn_checks("after_rst", 1);

    check("max_sclk_low_gap_le2", 32'(max_low <= 2), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
